// File: rtl/bcd_disp_pkg.sv
// Shared constants and the seven-segment encoder for the BCD up/down display.
// Segment patterns are active-low {a,b,c,d,e,f,g,dp}, bit 7 = segment a.
package bcd_disp_pkg;

    localparam logic [3:0] BCD_MAX = 4'h9;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg7_encode(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_updown_display_if.sv
// Control inputs and display/count outputs of the BCD up/down display.
// The master side (board glue or bench) drives controls; the slave side is the counter.
interface bcd_updown_display_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    en;
    logic                    dir;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    wrap;
    logic [7:0]              ss;
    logic [NUM_DIGITS-1:0]   sse;

    modport master (
        output en, dir, load, load_val,
        input  bcd, wrap, ss, sse
    );

    modport slave (
        input  en, dir, load, load_val,
        output bcd, wrap, ss, sse
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down counter; step comes from the carry/borrow of the digit below.
// Load sanitises codes above 9 to 0 and always wins over a step.
module bcd_digit_cell
    import bcd_disp_pkg::*;
(
    input  logic       clk100m,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       carry_out
);

    assign carry_out = step & ((dir & (digit == BCD_MAX)) | (~dir & (digit == 4'd0)));

    always_ff @(posedge clk100m) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= (load_digit > BCD_MAX) ? 4'd0 : load_digit;
        end else if (step) begin
            if (dir)
                digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
            else
                digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with a multiplexed seven-segment scan driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_updown_display
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 3,
    parameter int COUNT_DIV   = 16777216,
    parameter int REFRESH_DIV = 65536
) (
    input  logic clk100m,
    input  logic rst,
    bcd_updown_display_if.slave bus
);

    localparam int CW = $clog2(COUNT_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt_pre;
    logic                    cnt_tick;
    logic [RW-1:0]           ref_pre;
    logic                    ref_tick;
    logic [NUM_DIGITS:0]     chain;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic                    wrap_q;
    logic [IW-1:0]           scan_idx;
    logic [7:0]              ss_q;
    logic [NUM_DIGITS-1:0]   sse_q;
    logic [3:0]              show_digit;
    logic                    blank;
    logic [7:0]              seg_next;

    assign cnt_tick = (cnt_pre == CW'(COUNT_DIV - 1));
    assign ref_tick = (ref_pre == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clk100m) begin
        if (rst) begin
            cnt_pre <= '0;
            ref_pre <= '0;
        end else begin
            cnt_pre <= cnt_tick ? '0 : cnt_pre + CW'(1);
            ref_pre <= ref_tick ? '0 : ref_pre + RW'(1);
        end
    end

    // Carry/borrow ripples combinationally from digit 0 upward; the top carry is the wrap.
    assign chain[0] = cnt_tick & bus.en;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk100m    (clk100m),
            .rst        (rst),
            .step       (chain[g]),
            .dir        (bus.dir),
            .load       (bus.load),
            .load_digit (bus.load_val[4*g +: 4]),
            .digit      (bcd_q[4*g +: 4]),
            .carry_out  (chain[g+1])
        );
    end

    always_ff @(posedge clk100m) begin
        if (rst)
            wrap_q <= 1'b0;
        else
            wrap_q <= chain[NUM_DIGITS] & ~bus.load;
    end

    assign show_digit = bcd_q[4*scan_idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_from;

    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (bcd_q[4*(NUM_DIGITS-1) +: 4] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            zero_from[k] = zero_from[k+1] & (bcd_q[4*k +: 4] == 4'd0);
    end

    assign blank = (scan_idx != '0) & zero_from[scan_idx];
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? SEG_BLANK : seg7_encode(show_digit);

    // Enables and segments load on the same edge so the visible digit never tears.
    always_ff @(posedge clk100m) begin
        if (rst) begin
            scan_idx <= '0;
            ss_q     <= SEG_BLANK;
            sse_q    <= '1;
        end else if (ref_tick) begin
            sse_q    <= ~(NUM_DIGITS'(1) << scan_idx);
            ss_q     <= seg_next;
            scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.wrap = wrap_q;
    assign bus.ss   = ss_q;
    assign bus.sse  = sse_q;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Bench for bcd_updown_display (3 digits, COUNT_DIV=4, REFRESH_DIV=2) using a decimal-integer model.
// Honours LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_bcd_updown_display;

    localparam int ND   = 3;
    localparam int CDIV = 4;
    localparam int RDIV = 2;
    localparam int MODV = 1000;

    logic clk100m = 1'b0;
    logic rst;

    always #5 clk100m = ~clk100m;

    bcd_updown_display_if #(.NUM_DIGITS(ND)) bus();

    bcd_updown_display #(
        .NUM_DIGITS  (ND),
        .COUNT_DIV   (CDIV),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk100m (clk100m),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [11:0] load_val;
        logic [11:0] exp_bcd;
    } load_vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_tab [10];
    load_vec_t  vecs [6];

    int         m_val, m_pre, m_rpre, m_idx;
    logic       m_wrap;
    logic [7:0] m_ss;
    logic [2:0] m_sse;
    bit         m_tick, m_rtick;

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r *= 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int sanitize(input logic [11:0] lv);
        int v = 0;
        int d;
        for (int k = 0; k < ND; k++) begin
            d = int'(lv[4*k +: 4]);
            if (d > 9) d = 0;
            v += d * p10(k);
        end
        return v;
    endfunction

    // The model works on the count as a plain decimal integer, updated once per rising edge.
    task automatic modelStep();
        int old_val;
        if (rst) begin
            m_val = 0; m_pre = 0; m_rpre = 0; m_idx = 0;
            m_wrap = 1'b0; m_ss = 8'hFF; m_sse = 3'b111;
            m_tick = 1'b0; m_rtick = 1'b0;
        end else begin
            old_val = m_val;
            m_tick  = (m_pre == CDIV - 1);
            m_pre   = m_tick ? 0 : m_pre + 1;
            m_rtick = (m_rpre == RDIV - 1);
            m_rpre  = m_rtick ? 0 : m_rpre + 1;
            if (bus.load) begin
                m_val  = sanitize(bus.load_val);
                m_wrap = 1'b0;
            end else if (m_tick && bus.en) begin
                if (bus.dir) begin
                    m_wrap = (m_val == MODV - 1);
                    m_val  = (m_val + 1) % MODV;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val + MODV - 1) % MODV;
                end
            end else begin
                m_wrap = 1'b0;
            end
            if (m_rtick) begin
                m_sse = 3'b111 & ~(3'b001 << m_idx);
                m_ss  = seg_tab[(old_val / p10(m_idx)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
                if (m_idx > 0 && (old_val / p10(m_idx)) == 0) m_ss = 8'hFF;
`endif
                m_idx = (m_idx + 1) % ND;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        chk("bcd",  32'(bus.bcd),  32'(to_bcd(m_val)));
        chk("wrap", 32'(bus.wrap), 32'(m_wrap));
        chk("ss",   32'(bus.ss),   32'(m_ss));
        chk("sse",  32'(bus.sse),  32'(m_sse));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic d,
                                 input logic l, input logic [11:0] lv);
        rst          = r;
        bus.en       = e;
        bus.dir      = d;
        bus.load     = l;
        bus.load_val = lv;
        @(posedge clk100m);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic runUntilTick(input logic e, input logic d);
        bit got = 1'b0;
        for (int i = 0; i < 2 * CDIV && !got; i++) begin
            applyStimulus(1'b0, e, d, 1'b0, 12'h000);
            got = m_tick;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_timeout: got none, expected a count tick within %0d cycles", 2 * CDIV);
        end
    endtask

    logic [2:0] scan_sse [6];
    logic [7:0] scan_ss  [6];

    initial begin
        logic        r, e, d, l;
        logic [11:0] lv;

        seg_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        vecs[0] = '{12'h1A5, 12'h105};
        vecs[1] = '{12'h998, 12'h998};
        vecs[2] = '{12'hFFF, 12'h000};
        vecs[3] = '{12'h9B0, 12'h900};
        vecs[4] = '{12'hC3D, 12'h030};
        vecs[5] = '{12'h407, 12'h407};
        scan_sse = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b011};
        scan_ss  = '{8'h1F,  8'h03,  8'h99,  8'h1F,  8'h03,  8'h99};

        $display("[TB] starting");

        // Reset, then count up from release.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("rst_ss",  32'(bus.ss),  32'h0FF);
        chk("rst_sse", 32'(bus.sse), 32'h7);
        chk("rst_bcd", 32'(bus.bcd), 32'h000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("pre_first_tick", 32'(bus.bcd), 32'h000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("first_tick", 32'(bus.bcd), 32'h001);
        for (int i = 0; i < 36; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("count_40", 32'(bus.bcd), 32'h010);

        // Up wrap from 998.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h998);
        chk("load_998", 32'(bus.bcd), 32'h998);
        runUntilTick(1'b1, 1'b1);
        chk("up_999", 32'(bus.bcd), 32'h999);
        runUntilTick(1'b1, 1'b1);
        chk("up_wrap_bcd", 32'(bus.bcd),  32'h000);
        chk("up_wrap_hi",  32'(bus.wrap), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("up_wrap_lo", 32'(bus.wrap), 32'h0);

        // Down borrow from 000.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
        runUntilTick(1'b1, 1'b0);
        chk("dn_wrap_bcd", 32'(bus.bcd),  32'h999);
        chk("dn_wrap_hi",  32'(bus.wrap), 32'h1);
        runUntilTick(1'b1, 1'b0);
        chk("dn_998",     32'(bus.bcd),  32'h998);
        chk("dn_wrap_lo", 32'(bus.wrap), 32'h0);

        // Load sanitisation table.
        foreach (vecs[i]) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vecs[i].load_val);
            chk("load_tab", 32'(bus.bcd), 32'(vecs[i].exp_bcd));
        end

        // Load landing on a count tick consumes the tick.
        for (int i = 0; i < 2 * CDIV && m_pre != CDIV - 1; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
        chk("load_on_tick_seen", 32'(m_tick), 32'h1);
        chk("load_on_tick_bcd",  32'(bus.bcd),  32'h123);
        chk("load_on_tick_wrap", 32'(bus.wrap), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("load_on_tick_hold", 32'(bus.bcd), 32'h123);

        // Scan order over six refresh ticks with a held value of 407.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'h407);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            chk("scan_sse", 32'(bus.sse), 32'(scan_sse[k]));
            chk("scan_ss",  32'(bus.ss),  32'(scan_ss[k]));
        end

        // Reset in the middle of counting at 555.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h555);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("midrst_bcd",  32'(bus.bcd),  32'h000);
        chk("midrst_ss",   32'(bus.ss),   32'h0FF);
        chk("midrst_sse",  32'(bus.sse),  32'h7);
        chk("midrst_wrap", 32'(bus.wrap), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("midrst_hold", 32'(bus.bcd), 32'h000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("midrst_resume", 32'(bus.bcd), 32'h001);

        // Random traffic checked every cycle against the model.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1) != 0;
            lv = 12'($urandom);
            applyStimulus(r, e, d, l, lv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
